// File: rtl/timer_counter.sv
// Counting stage of the APB timer: prescaled-tick edge detector, loadable up/down counter, sticky ovf/udf flags.
// Optional interrupt output is built only when TIMER_CNT_IRQ_EN is defined.
module timer_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    input  logic             clr_udf,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic             udf
`ifdef TIMER_CNT_IRQ_EN
    ,
    input  logic             ovf_ie,
    input  logic             udf_ie,
    output logic             irq
`endif
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic             r_tick_d;
    logic             r_armed;
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic             w_rise;
    logic             w_ev;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic             w_udf_next;

    // A level already high when reset releases is not an edge: r_armed waits
    // for tick_in to be sampled low before any rise can be reported.
    assign w_rise    = tick_in & ~r_tick_d & r_armed;
    assign w_ev      = w_rise & en & ~load;
    assign w_set_ovf = w_ev & ~up_down & (r_cnt == MAX);
    assign w_set_udf = w_ev &  up_down & (r_cnt == '0);

    always_comb begin
        w_cnt_next = r_cnt;
        if (load) begin
            w_cnt_next = load_val;
        end else if (w_ev) begin
            if (up_down) begin
                w_cnt_next = r_cnt - WIDTH'(1);
            end else begin
                w_cnt_next = r_cnt + WIDTH'(1);
            end
        end
    end

    // Set beats a coincident clear; load leaves the flags alone.
    assign w_ovf_next = w_set_ovf | (r_ovf & ~clr_ovf);
    assign w_udf_next = w_set_udf | (r_udf & ~clr_udf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_tick_d <= tick_in;
            r_armed  <= r_armed | ~tick_in;
            r_cnt    <= w_cnt_next;
            r_ovf    <= w_ovf_next;
            r_udf    <= w_udf_next;
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;
    assign udf = r_udf;

`ifdef TIMER_CNT_IRQ_EN
    assign irq = (r_ovf & ovf_ie) | (r_udf & udf_ie);
`endif

endmodule

// File: doc/timer_counter.md
# timer_counter

Counting stage of the APB timer: consumes the divided clock produced by the timer prescaler as a level signal in the `clk` domain. It detects rising edges of that signal and turns each one into a single-cycle count event. It maintains a loadable up/down counter with sticky overflow and underflow flags, which the APB register file reads back and clears.

## Interface
- `WIDTH`, default 8: counter width in bits; `MAX` = 2^WIDTH−1.
- `clk`  in  1  system clock; the prescaler runs on the same clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_in`  in  1  prescaled clock level from the prescaler; synchronous to `clk`.
- `en`  in  1  count enable (TCR.EN).
- `up_down`  in  1  direction: 0 = count up, 1 = count down.
- `load`  in  1  single-cycle pulse; loads `load_val` into the counter.
- `load_val`  in  WIDTH  value to load (TDR).
- `clr_ovf`  in  1  single-cycle pulse; clears `ovf`.
- `clr_udf`  in  1  single-cycle pulse; clears `udf`.
- `cnt`  out  WIDTH  current count (TCNT).
- `ovf`  out  1  sticky overflow flag.
- `udf`  out  1  sticky underflow flag.
- `ovf_ie`, `udf_ie`  in  1  interrupt enables. Present only with `TIMER_CNT_IRQ_EN`.
- `irq`  out  1  interrupt request. Present only with `TIMER_CNT_IRQ_EN`.

## Operation
- **Edge detector**
  - `tick_d` register samples `tick_in` every cycle, regardless of `en` or `load`.
  - `rise = tick_in & ~tick_d`.
- **Count event:** `ev = rise & en & ~load`.
- **Counter update priority:**
  1. `load`: `cnt <= load_val`. A coincident rise is dropped, not deferred.
  2. `ev` with `up_down`=0: `cnt <= cnt+1`. At `MAX`, wrap to 0 and set `ovf`.
  3. `ev` with `up_down`=1: `cnt <= cnt−1`. At 0, wrap to `MAX` and set `udf`.
  4. Otherwise `cnt` holds.
- **Flags**
  - `ovf` and `udf` are sticky until their clear pulse.
  - If a set and its clear occur in the same cycle, set wins and the flag stays 1.
  - Loading never changes the flags.
- **Enable and direction changes**
  - `en` low: rises are ignored, but `tick_d` keeps tracking. Enabling while `tick_in` is already high produces no count until the next genuine rise.
  - `up_down` is sampled in the event cycle only. A direction change takes effect on the next event.
- **Reset mid-operation:** all state returns to reset values immediately. After release, the first count requires a 0→1 transition of `tick_in` observed after reset.

## Timing
- **Reset values:** `cnt`=0, `ovf`=0, `udf`=0, `tick_d`=0, `irq`=0.
- **Count latency:** if `tick_in` is first sampled high at clk edge N (with `tick_d`=0), `cnt` and the flags update at edge N. The new value is visible after edge N, one cycle after `tick_in` goes high.
- **Load latency:** `load` high at edge N → `cnt`=`load_val` after edge N.
- **Clear latency:** a clear pulse at edge N → flag reads 0 after edge N, unless a set occurs in the same cycle.
- **Fastest tick:** prescaler divide-by-2 (`tick_in` toggling every cycle) yields one event every 2 cycles. This must be handled with no missed events.
- **`irq` timing:** `irq` is combinational from the registered flags and enables, so it asserts in the same cycle as the flag.

## Configuration
- **`TIMER_CNT_IRQ_EN` defined**
  - Ports `ovf_ie`, `udf_ie`, `irq` exist.
  - `irq = (ovf & ovf_ie) | (udf & udf_ie)`.
  - `irq` deasserts when the flag is cleared or its enable is dropped.
- **`TIMER_CNT_IRQ_EN` undefined**
  - Those three ports and all associated logic are absent.
  - Flags behave identically; software polls `ovf`/`udf`.

## Test plan
- **Reset:** hold `rst_n`=0 with `tick_in` toggling → `cnt`=0, `ovf`=`udf`=0. Release with `tick_in` high → no count until `tick_in` falls and rises again.
- **Up wrap:** WIDTH=8; load 0xFD; `en`=1, `up_down`=0; `tick_in` divide-by-2 → `cnt` 0xFE, 0xFF, 0x00 on successive rises. `ovf` is set on the 0x00 step; `udf`=0.
- **Down wrap:** load 0x01, `up_down`=1, divide-by-4 tick → `cnt` 0x00, then 0xFF with `udf`=1. `clr_udf` pulse → `udf`=0 the next cycle.
- **Load collision:** `load`=1 with `load_val`=0x40 in the cycle of a rise → `cnt`=0x40 (not 0x41). The next rise gives 0x41.
- **Set/clear collision and enable:**
  - `clr_ovf` in the same cycle as a 0xFF→0x00 wrap → `ovf` stays 1.
  - `en` raised while `tick_in`=1 → `cnt` unchanged until the next rise.
- **IRQ (macro defined):** `ovf_ie`=1 and an overflow → `irq`=1 in the same cycle as `ovf`. `ovf_ie`=0 → `irq`=0 while `ovf` stays 1. With the macro undefined, the bench compiles without the `irq` ports.
